decode_regfile: RTL and testbench
=================================

Name: decode_regfile

Overview:
- Instruction-decode stage and 32x32 general-purpose register file of the single-cycle MIPS core.
- Drives the operand side of the execute unit:
  - first operand (rs contents),
  - second operand (rt contents),
  - extended 16-bit immediate.
- Closes the loop by writing back the execute result, load data or link address on the clock edge.

Parameters:
- DATA_W, 32, register and datapath width.
- REG_NUM, 32, number of architectural registers; register 0 is hardwired zero.
- LINK_REG, 31, destination index for jal link writes.

Ports:
- clock  input  1  core clock; all register writes on rising edge.
- reset  input  1  asynchronous, active-high; clears every register.
- Instruction  input  32  current instruction from fetch.
- opcplus4  input  32  PC+4 from fetch; link value for jal.
- ALU_result  input  32  execute-unit result for write-back.
- mem_data  input  32  load data from memory/IO.
- Jal  input  1  from control; write opcplus4 to LINK_REG.
- RegWrite  input  1  from control; enables write-back.
- MemtoReg  input  1  from control; 1 selects mem_data, 0 selects ALU_result.
- RegDst  input  1  from control; 1 selects rd (Instruction[15:11]), 0 selects rt (Instruction[20:16]).
- read_data_1  output  32  contents of rs (Instruction[25:21]).
- read_data_2  output  32  contents of rt (Instruction[20:16]).
- Sign_extend  output  32  extended Instruction[15:0].

Behaviour:
- Storage: REG_NUM x DATA_W flip-flop array. Reset is asynchronous, active-high, and forces all entries to 0 immediately, independent of clock. Reset asserted mid-write cancels that write. The first write occurs on the first rising clock edge after reset deasserts.
- Read ports are combinational from the array, with zero clock latency:
  - read_data_1 = reg[rs], read_data_2 = reg[rt].
  - Index 0 always reads 0.
  - Outputs are 0 during reset.
- No write-to-read bypass. A read of the register being written in the same cycle returns the old value; the new value is visible after the edge.
- Write address:
  - Jal=1 -> LINK_REG.
  - Else RegDst=1 -> rd.
  - Else rt.
- Write data:
  - Jal=1 -> opcplus4.
  - Else MemtoReg=1 -> mem_data.
  - Else ALU_result.
- Write enable: RegWrite | Jal. Jal forces a write even if RegWrite=0.
- Any write whose resolved address is 0 is discarded; reg[0] stays 0.
- Immediate extension (combinational) selects on opcode Instruction[31:26]:
  - 001100 andi, 001101 ori, 001110 xori, 001011 sltiu -> zero-extend: {16'h0000, imm}.
  - All other opcodes (including lui, beq, bne, lw, sw, addi, addiu, slti) -> sign-extend: {{16{imm[15]}}, imm}.
- Full 32-bit values are stored; no truncation or saturation.
- X-safety: with RegWrite=0 and Jal=0 the array must hold its contents regardless of data inputs.

Test Plan:
- Assert reset mid-cycle after writing 0x12345678 to reg 5 -> read_data_1 with rs=5 goes to 0 immediately, without waiting for a clock edge. All 32 registers read 0 after release.
- RegWrite=1, RegDst=1, MemtoReg=0, rd=8, ALU_result=0xDEADBEEF; same cycle rs=8:
  - read_data_1 = old 0 before the edge, 0xDEADBEEF after it.
  - With MemtoReg=1, mem_data=0x0000ABCD, rt=9, RegDst=0 -> reg 9 = 0x0000ABCD.
- Write to register 0 via rd=0 and via rt=0 with 0xFFFFFFFF -> reg 0 reads 0 on both ports afterwards.
- Jal=1, RegWrite=0, opcplus4=0x00400024, RegDst=1, rd=3 -> reg 31 = 0x00400024 after the edge. Reg 3 is unchanged.
- Sign_extend with imm=0x8001:
  - opcode 001000 (addi) -> 0xFFFF8001.
  - opcode 001101 (ori) -> 0x00008001.
  - opcode 001011 (sltiu) -> 0x00008001.
  - opcode 000100 (beq) -> 0xFFFF8001.
  - imm=0x7FFF with addi -> 0x00007FFF.
- Hold check: RegWrite=0, Jal=0, random ALU_result/mem_data/Instruction for 100 cycles -> a preloaded pattern (reg[i]=i*0x01010101) is unchanged on readback of all 32 registers.

Source files
------------

// File: rtl/decode_regfile.sv
// Decode stage: 32-entry register file with combinational rs/rt reads and edge-triggered write-back,
// plus opcode-driven immediate extension. Reads have zero latency; there is no flow control.
module decode_regfile #(
   parameter int DATA_W   = 32,
   parameter int REG_NUM  = 32,
   parameter int LINK_REG = 31
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       Instruction,
   input  logic [DATA_W-1:0] opcplus4,
   input  logic [DATA_W-1:0] ALU_result,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              Jal,
   input  logic              RegWrite,
   input  logic              MemtoReg,
   input  logic              RegDst,
   output logic [DATA_W-1:0] read_data_1,
   output logic [DATA_W-1:0] read_data_2,
   output logic [DATA_W-1:0] Sign_extend
);

   localparam int AW = 5;
   localparam logic [AW-1:0] LINK_IDX = AW'(LINK_REG);

   logic [DATA_W-1:0] regs_q [REG_NUM];

   logic [5:0]        opcode;
   logic [AW-1:0]     rs_addr;
   logic [AW-1:0]     rt_addr;
   logic [AW-1:0]     rd_addr;
   logic [15:0]       imm;
   logic              zero_ext;
   logic              wr_en_d;
   logic [AW-1:0]     wr_addr_d;
   logic [DATA_W-1:0] wr_data_d;

   assign opcode  = Instruction[31:26];
   assign rs_addr = Instruction[25:21];
   assign rt_addr = Instruction[20:16];
   assign rd_addr = Instruction[15:11];
   assign imm     = Instruction[15:0];

   // Jal overrides both the destination and the data, and forces the write on.
   always_comb begin
      wr_en_d   = RegWrite | Jal;
      wr_addr_d = rt_addr;
      wr_data_d = ALU_result;
      if (Jal) begin
         wr_addr_d = LINK_IDX;
         wr_data_d = opcplus4;
      end else begin
         if (RegDst) begin
            wr_addr_d = rd_addr;
         end
         if (MemtoReg) begin
            wr_data_d = mem_data;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < REG_NUM; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en_d && (wr_addr_d != '0)) begin
         regs_q[wr_addr_d] <= wr_data_d;
      end
   end

   // No bypass: a same-cycle read of the write target sees the pre-edge value.
   assign read_data_1 = (rs_addr == '0) ? '0 : regs_q[rs_addr];
   assign read_data_2 = (rt_addr == '0) ? '0 : regs_q[rt_addr];

   always_comb begin
      zero_ext = 1'b0;
      case (opcode)
         6'b001100, 6'b001101, 6'b001110, 6'b001011: zero_ext = 1'b1;
         default:                                    zero_ext = 1'b0;
      endcase
   end

   assign Sign_extend = zero_ext ? {{(DATA_W-16){1'b0}}, imm}
                                 : {{(DATA_W-16){imm[15]}}, imm};

endmodule

// File: tb/tb_decode_regfile.sv
// Directed plus randomized bench for decode_regfile against an array-based reference model.
module tb_decode_regfile;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] Instruction;
   logic [31:0] opcplus4;
   logic [31:0] ALU_result;
   logic [31:0] mem_data;
   logic        Jal;
   logic        RegWrite;
   logic        MemtoReg;
   logic        RegDst;
   logic [31:0] read_data_1;
   logic [31:0] read_data_2;
   logic [31:0] Sign_extend;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] model [32];

   decode_regfile #(.DATA_W(32), .REG_NUM(32), .LINK_REG(31)) dut (
      .clock       (clock),
      .reset       (reset),
      .Instruction (Instruction),
      .opcplus4    (opcplus4),
      .ALU_result  (ALU_result),
      .mem_data    (mem_data),
      .Jal         (Jal),
      .RegWrite    (RegWrite),
      .MemtoReg    (MemtoReg),
      .RegDst      (RegDst),
      .read_data_1 (read_data_1),
      .read_data_2 (read_data_2),
      .Sign_extend (Sign_extend)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mkr(input int rs, input int rt, input int rd);
      return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 11'b0};
   endfunction

   function automatic logic [31:0] mki(input logic [5:0] op, input int rs, input int rt,
                                       input logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   // Logical ops and sltiu treat the immediate as unsigned; everything else is signed.
   function automatic logic [31:0] ref_ext(input logic [31:0] ins);
      logic [5:0] op;
      op = ins[31:26];
      if (op == 6'd12 || op == 6'd13 || op == 6'd14 || op == 6'd11)
         return 32'(ins[15:0]);
      return 32'($signed(ins[15:0]));
   endfunction

   task automatic model_edge();
      int addr;
      logic [31:0] data;
      if (RegWrite || Jal) begin
         if (Jal) begin
            addr = 31;
            data = opcplus4;
         end else begin
            addr = RegDst ? int'(Instruction[15:11]) : int'(Instruction[20:16]);
            data = MemtoReg ? mem_data : ALU_result;
         end
         if (addr != 0) model[addr] = data;
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      RegWrite = 1'b0;
      Jal      = 1'b0;
      MemtoReg = 1'b0;
      RegDst   = 1'b0;
   endtask

   task automatic readback(input string tag);
      for (int i = 0; i < 32; i++) begin
         Instruction = mkr(i, 31 - i, 0);
         #1;
         check({tag, "_rd1"}, read_data_1, model[i]);
         check({tag, "_rd2"}, read_data_2, model[31 - i]);
      end
   endtask

   initial begin
      logic [31:0] exp;
      reset       = 1'b1;
      Instruction = mkr(5, 5, 0);
      opcplus4    = '0;
      ALU_result  = '0;
      mem_data    = '0;
      idle();
      for (int i = 0; i < 32; i++) model[i] = '0;
      #1;
      check("reset_rd1", read_data_1, 32'h0);
      readback("reset_hold");

      @(negedge clock);
      reset = 1'b0;

      // Write reg 5, then assert reset mid-cycle with the write still requested.
      RegWrite    = 1'b1;
      RegDst      = 1'b1;
      Instruction = mkr(5, 0, 5);
      ALU_result  = 32'h12345678;
      tick();
      check("reg5_written", read_data_1, 32'h12345678);
      #3;
      reset = 1'b1;
      #1;
      check("async_reset_rd1", read_data_1, 32'h0);
      @(posedge clock);
      #2;
      reset = 1'b0;
      idle();
      for (int i = 0; i < 32; i++) model[i] = '0;
      readback("post_reset");

      // Same-cycle read of the write target returns the old value.
      RegWrite    = 1'b1;
      RegDst      = 1'b1;
      MemtoReg    = 1'b0;
      Instruction = mkr(8, 0, 8);
      ALU_result  = 32'hDEADBEEF;
      mem_data    = 32'h0BADF00D;
      #1;
      check("rd8_before_edge", read_data_1, 32'h0);
      tick();
      check("rd8_after_edge", read_data_1, 32'hDEADBEEF);

      RegDst      = 1'b0;
      MemtoReg    = 1'b1;
      Instruction = mkr(0, 9, 0);
      mem_data    = 32'h0000ABCD;
      ALU_result  = 32'h11111111;
      tick();
      idle();
      check("reg9_memdata", read_data_2, 32'h0000ABCD);

      // Writes aimed at register 0 through rd and through rt.
      RegWrite    = 1'b1;
      RegDst      = 1'b1;
      Instruction = mkr(0, 0, 0);
      ALU_result  = 32'hFFFFFFFF;
      tick();
      RegDst = 1'b0;
      tick();
      idle();
      check("reg0_rd1", read_data_1, 32'h0);
      check("reg0_rd2", read_data_2, 32'h0);

      // Jal writes the link register even with RegWrite low and ignores rd.
      RegWrite    = 1'b1;
      RegDst      = 1'b1;
      Instruction = mkr(0, 0, 3);
      ALU_result  = 32'hA5A50003;
      tick();
      RegWrite    = 1'b0;
      Jal         = 1'b1;
      Instruction = mkr(31, 3, 3);
      opcplus4    = 32'h00400024;
      ALU_result  = 32'h77777777;
      tick();
      idle();
      check("jal_reg31", read_data_1, 32'h00400024);
      check("jal_reg3_kept", read_data_2, 32'hA5A50003);

      Instruction = mki(6'b001000, 0, 0, 16'h8001); #1;
      check("ext_addi", Sign_extend, 32'hFFFF8001);
      Instruction = mki(6'b001101, 0, 0, 16'h8001); #1;
      check("ext_ori", Sign_extend, 32'h00008001);
      Instruction = mki(6'b001011, 0, 0, 16'h8001); #1;
      check("ext_sltiu", Sign_extend, 32'h00008001);
      Instruction = mki(6'b000100, 0, 0, 16'h8001); #1;
      check("ext_beq", Sign_extend, 32'hFFFF8001);
      Instruction = mki(6'b001000, 0, 0, 16'h7FFF); #1;
      check("ext_addi_pos", Sign_extend, 32'h00007FFF);
      Instruction = mki(6'b001100, 0, 0, 16'hF00F); #1;
      check("ext_andi", Sign_extend, 32'h0000F00F);
      Instruction = mki(6'b001111, 0, 0, 16'hF00F); #1;
      check("ext_lui", Sign_extend, 32'hFFFFF00F);

      // Preload reg[i] = i * 0x01010101, then hammer the data inputs with writes disabled.
      RegWrite = 1'b1;
      RegDst   = 1'b1;
      for (int i = 1; i < 32; i++) begin
         Instruction = mkr(0, 0, i);
         ALU_result  = 32'(i) * 32'h01010101;
         tick();
      end
      idle();
      for (int c = 0; c < 100; c++) begin
         Instruction = $urandom;
         ALU_result  = $urandom;
         mem_data    = $urandom;
         opcplus4    = $urandom;
         MemtoReg    = 1'($urandom_range(0, 1));
         RegDst      = 1'($urandom_range(0, 1));
         #1;
         check("hold_ext", Sign_extend, ref_ext(Instruction));
         tick();
      end
      idle();
      for (int i = 0; i < 32; i++) begin
         Instruction = mkr(i, 31 - i, 0);
         #1;
         exp = 32'(i) * 32'h01010101;
         check("hold_pattern_rd1", read_data_1, exp);
         exp = 32'(31 - i) * 32'h01010101;
         check("hold_pattern_rd2", read_data_2, exp);
      end

      // Fully random traffic against the reference model.
      for (int c = 0; c < 300; c++) begin
         Instruction = $urandom;
         ALU_result  = $urandom;
         mem_data    = $urandom;
         opcplus4    = $urandom;
         RegWrite    = 1'($urandom_range(0, 1));
         MemtoReg    = 1'($urandom_range(0, 1));
         RegDst      = 1'($urandom_range(0, 1));
         Jal         = ($urandom_range(0, 7) == 0);
         #1;
         check("rand_rd1", read_data_1, model[Instruction[25:21]]);
         check("rand_rd2", read_data_2, model[Instruction[20:16]]);
         check("rand_ext", Sign_extend, ref_ext(Instruction));
         tick();
      end
      idle();
      readback("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
